rtlola_output_collector: RTL
============================

# rtlola_output_collector

Sink-side companion to the Clash-generated RTLola monitor (`topEntity`). It watches the monitor's low-level-clock stage counter and, at the final LLC stage of each high-level cycle, snapshots every active output stream (`a`, `b`, `c`). The snapshot is serialised into a small FIFO as tagged entries, each carrying a stream id, a value and an optional HLC cycle number. A downstream reader (UART bridge, trace buffer, test harness) drains the FIFO over a valid/ready handshake.

## Interface
Parameters:
- `DATA_W`, 64, width of stream values and of `llc_stage`.
- `LAST_STAGE`, 4, LLC stage index at which monitor outputs are final. The monitor has `LAST_STAGE+1` stages; `LAST_STAGE` must be ≥ 3.
- `DEPTH`, 8, FIFO entries. Must be a power of two, ≥ 4.
- `CYC_W`, 32, HLC cycle counter width.

Ports:
- `clk` in 1: single clock, shared with the monitor.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: monitor enable. Gates capture only.
- `llc_stage` in `DATA_W`: signed monitor stage counter.
- `output_a`, `output_b`, `output_c` in `DATA_W`: signed stream values.
- `output_a_aktv`, `output_b_aktv`, `output_c_aktv` in 1: stream-active flags.
- `out_valid` out 1: the FIFO head is valid.
- `out_ready` in 1: the reader accepts the head.
- `out_id` out 2: stream id of the head. 0 = a, 1 = b, 2 = c.
- `out_data` out `DATA_W`: value of the head.
- `out_cycle` out `CYC_W`: HLC cycle number of the head.
- `out_count` out log2(`DEPTH`)+1: FIFO occupancy.
- `overflow` out 1: sticky flag, set when any entry is dropped.

## Operation
- **Capture.** A capture occurs at the rising edge when `en` = 1 and `llc_stage` == `LAST_STAGE`. On capture:
  - register all three values;
  - set the `pending` mask to {c_aktv, b_aktv, a_aktv};
  - latch `cyc` into `snap_cyc`;
  - increment `cyc`, wrapping at 2^`CYC_W`.
- A capture with all aktv flags at 0 still increments `cyc`. No entries are produced for it.
- **Serialise.** Each cycle in which `pending` ≠ 0, push the lowest-indexed pending stream into the FIFO and clear its bit. At most one push per cycle, so order is always a, b, c.
- **FIFO full on push.** If the FIFO is full and no pop happens in the same cycle, the entry is dropped, its bit is still cleared, and `overflow` is set.
- **Push and pop in the same cycle.** Always legal, including when the FIFO is full. Occupancy is unchanged.
- **New capture while `pending` ≠ 0.** This is only reachable through `en`/stage glitches. The new snapshot replaces the old one, the remaining pending bits are lost, and `overflow` is set.
- **Pop.** A pop occurs when `out_valid` && `out_ready`. The head advances on that edge. While `out_valid` = 0, `out_ready` is ignored.
- **Independence from `en`.** Serialisation and draining continue when `en` = 0.
- **Reset.** `rst` takes priority over everything, including mid-serialisation. It clears:
  - `pending`, `cyc` and the FIFO pointers;
  - `overflow`.
- **Output values after reset.** `out_valid` = 0, `out_count` = 0, `out_id` = 0, `out_data` = 0, `out_cycle` = 0.
- **No head.** While `out_valid` = 0, `out_id`, `out_data` and `out_cycle` are 0.

## Timing
- Capture edge E0 registers the snapshot.
- The first push is written at edge E0+1, and `out_valid` rises after E0+1.
- The k-th active stream of a snapshot (k = 0..2) is visible no earlier than after E0+1+k.
- All pushes complete before the next capture, because `LAST_STAGE` ≥ 3.
- The FIFO head outputs are registered, so there is no combinational path from `out_ready` to `out_valid`, `out_id`, `out_data` or `out_cycle`.
- `out_count` and `overflow` update on the same edge as the push or pop that changes them.

## Configuration
- **`COLLECTOR_TIMESTAMP_EN` defined:**
  - the `cyc` counter and `snap_cyc` are built;
  - each FIFO entry stores `CYC_W` bits of cycle number;
  - `out_cycle` reports the HLC cycle of the capture, starting at 0 after reset.
- **Not defined:**
  - the counter and the cycle storage are removed;
  - `out_cycle` is tied to 0;
  - all other behaviour is identical.

## Test plan
- **Basic ordering.** Reset, then hold `en` = 1 with stage cycling 0..4. At stage 4 drive a = 5 (aktv), b = 7 (aktv), c = 9 (inactive), with `out_ready` = 1.
  - Expect entries (0,5,cyc 0) then (1,7,cyc 0), one cycle apart.
  - The first entry is valid after E0+1.
- **Cycle tagging.** Hold `out_ready` = 0 for three HLC cycles with only c active each time: c = 10, 20, 30.
  - Expect `out_count` = 3.
  - Then drain to get (2,10,0), (2,20,1), (2,30,2).
- **Overflow.** With `DEPTH` = 8 and `out_ready` = 0, make all three streams active for 3 HLC cycles (9 entries).
  - Expect `out_count` = 8 and `overflow` = 1.
  - The ninth entry (stream c, cycle 2) is absent when drained.
- **Full with simultaneous push and pop.** With the FIFO at 8, assert `out_ready` = 1 during serialisation.
  - Expect no drop, `overflow` stays 0, and `out_count` stays 8.
- **Reset mid-operation.** Assert `rst` one cycle after a capture with all three streams active.
  - Expect `out_valid` = 0, `out_count` = 0 and `overflow` = 0 next cycle, with no later pushes.
  - The next capture is tagged cyc 0.
- **`en` gating.** With `en` = 0 and stage = 4 for five HLC periods, expect no entries and `cyc` unchanged.

Source files
------------

// File: rtl/rtlola_output_collector.sv
// rtlola_output_collector: snapshots the RTLola monitor's active output streams
// at the last LLC stage of every HLC cycle and serialises them into a FIFO.
// Ports: clk, rst (sync, active-high), en, llc_stage, output_{a,b,c}, output_*_aktv;
// out_valid/out_ready handshake, head out_id/out_data/out_cycle, out_count, overflow.
// Option: define COLLECTOR_TIMESTAMP_EN to tag each entry with its HLC cycle number.
module rtlola_output_collector #(
    parameter int DATA_W     = 64,
    parameter int LAST_STAGE = 4,
    parameter int DEPTH      = 8,
    parameter int CYC_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DATA_W-1:0]       llc_stage,
    input  logic [DATA_W-1:0]       output_a,
    input  logic [DATA_W-1:0]       output_b,
    input  logic [DATA_W-1:0]       output_c,
    input  logic                    output_a_aktv,
    input  logic                    output_b_aktv,
    input  logic                    output_c_aktv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_id,
    output logic [DATA_W-1:0]       out_data,
    output logic [CYC_W-1:0]        out_cycle,
    output logic [$clog2(DEPTH):0]  out_count,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] LAST = DATA_W'(LAST_STAGE);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [2:0]        pend_q, pend_d;
    logic [DATA_W-1:0] va_q, vb_q, vc_q;
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        id_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic              capture, push, pop, full, wr_en, drop;
    logic [1:0]        push_id;
    logic [DATA_W-1:0] push_val;

    assign capture = en && (llc_stage == LAST);
    assign push    = (pend_q != 3'd0);
    assign full    = (cnt_q == FULL);
    assign pop     = out_valid && out_ready;
    // A full FIFO still accepts the push when the head leaves on the same edge.
    assign wr_en   = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_comb begin
        push_id  = 2'd2;
        push_val = vc_q;
        if (pend_q[0]) begin
            push_id  = 2'd0;
            push_val = va_q;
        end else if (pend_q[1]) begin
            push_id  = 2'd1;
            push_val = vb_q;
        end
    end

    always_comb begin
        pend_d = pend_q & (pend_q - 3'd1);
        if (capture)
            pend_d = {output_c_aktv, output_b_aktv, output_a_aktv};
        cnt_d = cnt_q;
        if (wr_en && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (!wr_en && pop)
            cnt_d = cnt_q - 1'b1;
        // A capture over unfinished serialisation loses the remaining streams.
        ovf_d = ovf_q || drop || (capture && push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            if (wr_en)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            va_q <= output_a;
            vb_q <= output_b;
            vc_q <= output_c;
        end
        if (wr_en) begin
            id_mem[wr_q]   <= push_id;
            data_mem[wr_q] <= push_val;
        end
    end

    assign out_valid = (cnt_q != '0);
    assign out_id    = out_valid ? id_mem[rd_q] : 2'd0;
    assign out_data  = out_valid ? data_mem[rd_q] : '0;
    assign out_count = cnt_q;
    assign overflow  = ovf_q;

`ifdef COLLECTOR_TIMESTAMP_EN
    logic [CYC_W-1:0] cyc_q, snap_q;
    logic [CYC_W-1:0] cyc_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= '0;
            snap_q <= '0;
        end else if (capture) begin
            cyc_q  <= cyc_q + 1'b1;
            snap_q <= cyc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            cyc_mem[wr_q] <= snap_q;
    end

    assign out_cycle = out_valid ? cyc_mem[rd_q] : '0;
`else
    assign out_cycle = '0;
`endif

endmodule
